multi_channel_streamer: RTL and testbench
=========================================

Name: multi_channel_streamer

Overview:
- Parametrised N-channel sample source that replays DEPTH-entry per-channel buffers as a lock-step stream of N words per beat.
- Feeds adder_tree-class consumers through a valid/ready handshake.
- Adds what the fixed 8x32 shifter lacks: runtime buffer loading, programmable length, one-shot or loop mode, backpressure, abort, and a done pulse.

Parameters:
- NCH, 8, number of channels (>=1).
- DEPTH, 32, entries per channel (power of 2, >=2).
- W, 8, sample width in bits.
- AW, $clog2(DEPTH), address width (derived, not overridden).
- CW, max(1,$clog2(NCH)), channel-select width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  buffer write strobe.
- wr_ch  in  CW  channel to write.
- wr_addr  in  AW  entry to write.
- wr_data  in  W  write data.
- start  in  1  begin streaming (pulse).
- abort  in  1  stop streaming immediately (pulse).
- loop_mode  in  1  1 = wrap continuously, 0 = one-shot; sampled at start.
- length  in  AW+1  beats per pass, 1..DEPTH; 0 is treated as DEPTH; sampled at start.
- out_valid  out  1  beat present.
- out_ready  in  1  consumer accepts beat.
- out_data  out  NCH*W  channel c in bits [c*W +: W].
- out_idx  out  AW  buffer index of the current beat.
- busy  out  1  streaming in progress.
- done  out  1  one-cycle pulse when a one-shot pass completes.

Behaviour:
- Reset: all buffer entries 0, state IDLE, ptr 0, out_valid 0, out_data 0, out_idx 0, busy 0, done 0.
- States: IDLE and STREAM.
- IDLE:
  - wr_en writes mem[wr_ch][wr_addr] <= wr_data on the next edge.
  - wr_ch >= NCH: the write is ignored.
  - start=1: latch len (0 -> DEPTH) and loop flag, ptr <= 0, enter STREAM.
  - start and wr_en in the same cycle: the write lands first and is visible in beat 0.
- STREAM:
  - out_valid=1, busy=1.
  - out_data = all channels at ptr; out_idx = ptr. Both are registered and update only after a handshake.
  - Handshake = out_valid & out_ready. On a handshake with ptr != len-1: ptr <= ptr+1.
  - On a handshake with ptr == len-1:
    - loop flag set: ptr <= 0, stay in STREAM.
    - loop flag clear: enter IDLE, out_valid <= 0, done <= 1 for one cycle.
  - Without out_ready, data and idx hold stable indefinitely (no beat dropped or repeated).
  - wr_en and start are ignored while busy.
- Latency:
  - start at edge k gives out_valid=1 and beat 0 after edge k+1.
  - With out_ready held high, one beat per cycle, no bubbles, including across a loop wrap.
- Abort:
  - abort in STREAM: IDLE next edge, out_valid 0, no done pulse. A handshake in the same cycle still counts as consumed.
  - abort in IDLE: no effect.
  - abort and start together in IDLE: start wins.
- rst mid-stream: immediate return to reset state; the buffer is cleared.
- Buffer contents persist across passes and aborts. A new start replays the current contents.

Decomposition:
- Package streamer_pkg:
  - state enum {IDLE, STREAM}.
  - helper function for the length-0 -> DEPTH mapping.
  - default NCH/DEPTH/W constants shared with the adder_tree bench.
- Sub-module streamer_chan_mem: one channel's DEPTH x W register array.
  - Synchronous write, asynchronous read at ptr, synchronous clear on rst.
  - Instantiated NCH times via generate.
- The top level holds the FSM, ptr, and output registers.

Test Plan:
- Load: write mem[c][i] = c*32+i for all 8x32 entries; length=0, loop=0, start, out_ready=1.
  - Expect 32 consecutive beats; beat i channel c = c*32+i; out_idx = i.
  - done pulses exactly once, the cycle after beat 31; busy falls.
- Backpressure: length=4, out_ready toggling 1,0,0,1,...
  - Expect data held stable while stalled.
  - Beats 0..3 delivered exactly once each, then done.
- Loop mode: length=3, loop=1, out_ready=1 for 10 cycles.
  - Expect out_idx sequence 0,1,2,0,1,2,0,1,2,0; no done.
  - Then abort: out_valid=0 next cycle, no done.
- Boundary: length=1, one-shot.
  - Expect a single beat idx 0, then done.
  - Then write mem[0][0]=0xFF while idle and restart: beat 0 channel 0 = 0xFF.
- Ignored inputs while busy:
  - wr_en to mem[2][5]=0xAA during a stream -> a later replay still shows the old value.
  - start while busy -> no pointer restart.
- Reset mid-stream at beat 7:
  - All outputs 0 next cycle.
  - A restart after reset streams all-zero data.

Source files
------------

// File: rtl/streamer_pkg.sv
// streamer_pkg: shared types, defaults and helpers for the multi-channel streamer
// Provides the FSM state type, the default geometry shared with the adder_tree bench,
// and the length mapping that treats 0 as a full-buffer pass.
package streamer_pkg;

    typedef enum logic {IDLE, STREAM} state_t;

    localparam int DEF_NCH = 8;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_W = 8;

    function automatic int unsigned eff_len(input int unsigned len, input int unsigned depth);
        return len == 0 ? depth : len;
    endfunction

endpackage

// File: rtl/streamer_chan_mem.sv
// streamer_chan_mem: one channel's DEPTH x W sample buffer
// Ports: clk, rst (sync clear of every entry), we/waddr/wdata (sync write),
// raddr/rdata (combinational read).
module streamer_chan_mem #(
    parameter int DEPTH = 32,
    parameter int W = 8,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/multi_channel_streamer.sv
// multi_channel_streamer: replays NCH per-channel buffers as a lock-step valid/ready stream
// Ports: clk, rst (sync, active-high); wr_en/wr_ch/wr_addr/wr_data load buffers while idle;
// start/abort/loop_mode/length control a pass; out_valid/out_ready/out_data/out_idx carry
// one beat of NCH samples; busy flags streaming; done pulses at the end of a one-shot pass.
module multi_channel_streamer import streamer_pkg::*; #(
    parameter int NCH = DEF_NCH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int W = DEF_W,
    parameter int AW = $clog2(DEPTH),
    parameter int CW = NCH > 1 ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [CW-1:0]  wr_ch,
    input  logic [AW-1:0]  wr_addr,
    input  logic [W-1:0]   wr_data,
    input  logic           start,
    input  logic           abort,
    input  logic           loop_mode,
    input  logic [AW:0]    length,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [NCH*W-1:0] out_data,
    output logic [AW-1:0]  out_idx,
    output logic           busy,
    output logic           done
);
    state_t state, state_n;
    logic [AW-1:0] ptr, ptr_n;
    logic [AW:0] len_r;
    logic loop_r, valid_n, done_n, load, hs, last;
    logic [NCH*W-1:0] rd;

    // Reads follow ptr_n so the output register captures the entry it is about to present.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        streamer_chan_mem #(.DEPTH(DEPTH), .W(W), .AW(AW)) u_mem (
            .clk(clk),
            .rst(rst),
            .we(wr_en && state == IDLE && wr_ch == CW'(c)),
            .waddr(wr_addr),
            .wdata(wr_data),
            .raddr(ptr_n),
            .rdata(rd[c*W +: W])
        );
    end

    // The first STREAM cycle primes the output register, so a write landing with start
    // is already in the buffer when beat 0 is captured.
    always_comb begin
        hs = out_valid & out_ready;
        last = {1'b0, ptr} == len_r - (AW+1)'(1);
        state_n = state;
        ptr_n = ptr;
        valid_n = out_valid;
        done_n = 1'b0;
        load = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                state_n = STREAM;
                ptr_n = '0;
            end
        end else if (abort) begin
            state_n = IDLE;
            valid_n = 1'b0;
        end else if (!out_valid) begin
            valid_n = 1'b1;
            load = 1'b1;
        end else if (hs) begin
            if (!last) begin
                ptr_n = ptr + AW'(1);
                load = 1'b1;
            end else if (loop_r) begin
                ptr_n = '0;
                load = 1'b1;
            end else begin
                state_n = IDLE;
                valid_n = 1'b0;
                done_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr <= '0;
            len_r <= '0;
            loop_r <= 1'b0;
            out_valid <= 1'b0;
            out_data <= '0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            out_valid <= valid_n;
            done <= done_n;
            if (state == IDLE && start) begin
                len_r <= (AW+1)'(eff_len(32'(length), DEPTH));
                loop_r <= loop_mode;
            end
            if (load) out_data <= rd;
        end
    end

    assign out_idx = ptr;
    assign busy = state == STREAM;

endmodule

// File: tb/tb_multi_channel_streamer.sv
// tb_multi_channel_streamer: scoreboard bench for multi_channel_streamer
module tb_multi_channel_streamer;
    localparam int NCH = 8, DEPTH = 32, W = 8, AW = 5, CW = 3;

    logic clk = 0, rst = 1, wr_en = 0, start = 0, abort = 0, loop_mode = 0, out_ready = 0;
    logic [CW-1:0] wr_ch = 0;
    logic [AW-1:0] wr_addr = 0;
    logic [W-1:0] wr_data = 0;
    logic [AW:0] length = 0;
    logic out_valid, busy, done;
    logic [NCH*W-1:0] out_data;
    logic [AW-1:0] out_idx;

    multi_channel_streamer #(.NCH(NCH), .DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .abort(abort), .loop_mode(loop_mode),
        .length(length), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [NCH*W-1:0] data;
    } beat_t;

    beat_t sb[$];
    logic [W-1:0] tbm [NCH][DEPTH];
    int checks = 0, errors = 0, done_cnt = 0;
    logic held = 0;
    logic [NCH*W-1:0] hdata;
    logic [AW-1:0] hidx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NCH*W-1:0] beat_data(input int i);
        logic [NCH*W-1:0] d;
        for (int c = 0; c < NCH; c++) d[c*W +: W] = tbm[c][i];
        return d;
    endfunction

    task automatic push_beats(input int n, input int plen);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.idx = AW'(k % plen);
            b.data = beat_data(k % plen);
            sb.push_back(b);
        end
    endtask

    task automatic wr(input int c, input int a, input int d);
        wr_en = 1;
        wr_ch = CW'(c);
        wr_addr = AW'(a);
        wr_data = W'(d);
        tbm[c][a] = W'(d);
        tick();
        wr_en = 0;
    endtask

    task automatic go(input int len, input bit lp);
        length = (AW+1)'(len);
        loop_mode = lp;
        start = 1;
        tick();
        start = 0;
    endtask

    // Runs until done, driving out_ready from pat and optionally injecting a write+start
    // at cycle inj that must be ignored because the streamer is busy.
    task automatic wait_done(input string name, input int exp_cyc, input logic [3:0] pat, input int inj);
        int cyc;
        bit seen;
        int d0;
        d0 = done_cnt;
        seen = 0;
        for (cyc = 1; cyc < 200; cyc++) begin
            out_ready = pat[cyc % 4];
            wr_en = cyc == inj;
            start = cyc == inj;
            wr_ch = 2;
            wr_addr = 5;
            wr_data = 8'hAA;
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        wr_en = 0;
        start = 0;
        chk({name, "_done_seen"}, 64'(seen), 1);
        if (exp_cyc != 0) chk({name, "_cycles"}, 64'(cyc), 64'(exp_cyc));
        chk({name, "_busy_low"}, 64'(busy), 0);
        chk({name, "_valid_low"}, 64'(out_valid), 0);
        tick();
        chk({name, "_done_pulse"}, 64'(done), 0);
        chk({name, "_done_count"}, 64'(done_cnt - d0), 1);
        chk({name, "_sb_empty"}, 64'(sb.size()), 0);
    endtask

    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            held = 0;
        end else begin
            if (done) done_cnt++;
            if (held && out_valid) begin
                chk("stall_data", 64'(out_data), 64'(hdata));
                chk("stall_idx", 64'(out_idx), 64'(hidx));
            end
            held = out_valid && !out_ready;
            hdata = out_data;
            hidx = out_idx;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'(out_idx), 64'hFFFF);
                end else begin
                    b = sb.pop_front();
                    chk("beat_idx", 64'(out_idx), 64'(b.idx));
                    chk("beat_data", 64'(out_data), 64'(b.data));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < DEPTH; i++) tbm[c][i] = '0;
        tick();
        tick();
        rst = 0;
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_data", 64'(out_data), 0);
        chk("rst_idx", 64'(out_idx), 0);

        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < DEPTH; i++) wr(c, i, c * 32 + i);
        push_beats(32, 32);
        go(0, 0);
        chk("full_busy_after_start", 64'(busy), 1);
        wait_done("full", 34, 4'b1111, 0);

        push_beats(4, 4);
        go(4, 0);
        wait_done("bp", 0, 4'b1001, 0);

        d0 = done_cnt;
        push_beats(10, 3);
        out_ready = 1;
        go(3, 1);
        tick();
        repeat (10) tick();
        out_ready = 0;
        abort = 1;
        tick();
        abort = 0;
        chk("abort_valid", 64'(out_valid), 0);
        chk("abort_busy", 64'(busy), 0);
        tick();
        chk("loop_no_done", 64'(done_cnt - d0), 0);
        chk("loop_sb_empty", 64'(sb.size()), 0);

        push_beats(1, 1);
        go(1, 0);
        wait_done("len1", 3, 4'b1111, 0);
        tbm[0][0] = 8'hFF;
        push_beats(1, 1);
        wr_en = 1;
        wr_ch = 0;
        wr_addr = 0;
        wr_data = 8'hFF;
        go(1, 0);
        wr_en = 0;
        wait_done("len1_wr", 3, 4'b1111, 0);

        push_beats(8, 8);
        go(8, 0);
        wait_done("busy_ign", 10, 4'b1111, 4);
        push_beats(8, 8);
        go(8, 0);
        wait_done("replay", 10, 4'b1111, 0);
        chk("model_old_value", 64'(tbm[2][5]), 64'd69);

        push_beats(7, 32);
        out_ready = 1;
        go(0, 0);
        tick();
        repeat (7) tick();
        chk("pre_rst_idx", 64'(out_idx), 7);
        out_ready = 0;
        rst = 1;
        tick();
        rst = 0;
        chk("mid_rst_valid", 64'(out_valid), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_done", 64'(done), 0);
        chk("mid_rst_data", 64'(out_data), 0);
        chk("mid_rst_idx", 64'(out_idx), 0);
        chk("mid_rst_sb_empty", 64'(sb.size()), 0);
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < DEPTH; i++) tbm[c][i] = '0;
        push_beats(4, 4);
        go(4, 0);
        wait_done("zero", 6, 4'b1111, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
